// File: rtl/wait_mem_ctrl.sv
// wait_mem_ctrl: single-port 32-bit data memory behind a wait-state
// controller. A request accepted in IDLE is held for LATENCY wait cycles in
// BUSY, then completes in DONE with a one-cycle resp_valid pulse; the CPU is
// stalled from the accept cycle until (not including) DONE.
//
// Parameters:
//   DEPTH    memory size in 32-bit words (power of two, 4..4096)
//   LATENCY  wait cycles before the response (0..15)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/we/addr/wdata/size  CPU request (size: 00 byte, 01 half, 1x word)
//   req_ready           controller idle, request can be accepted
//   stall               CPU must hold PC/IR/ALUOut
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load data, zero unless resp_valid
//   misalign_err        misaligned access flag, pulses with resp_valid
//
// Build option: define WAIT_MEM_CTRL_SUBWORD_EN to honour req_size (byte and
// halfword accesses). Without it every access is a full word.

module wait_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic        lat_mis;
  logic [31:0] mem [DEPTH];

  // Address bits above the array wrap around and are ignored.
  logic [AW-1:0] idx;
  assign idx = lat_addr[AW+1:2];

`ifdef WAIT_MEM_CTRL_SUBWORD_EN
  logic [1:0] lat_size;

  function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  logic unused_hi;
  assign unused_hi = ^lat_addr[31:AW+2];
`else
  function automatic logic is_misaligned(input logic [1:0] a);
    return a != 2'b00;
  endfunction

  logic unused_hi;
  assign unused_hi = ^{lat_addr[31:AW+2], req_size};
`endif

  // Control FSM. resp_valid is registered and tracks entry into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_mis    <= 1'b0;
`ifdef WAIT_MEM_CTRL_SUBWORD_EN
      lat_size   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_we    <= req_we;
`ifdef WAIT_MEM_CTRL_SUBWORD_EN
            lat_size  <= req_size;
            lat_mis   <= is_misaligned(req_addr[1:0], req_size);
`else
            lat_mis   <= is_misaligned(req_addr[1:0]);
`endif
            if (LATENCY == 0) begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= 4'(LATENCY);
            end
          end
        end
        BUSY: begin
          // Counter starts at LATENCY; leaving on 1 gives LATENCY BUSY cycles.
          if (cnt == 4'd1) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign stall     = ((state == IDLE) && req_valid) || (state == BUSY);

  // Byte-lane enables and lane-replicated write data.
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rword;
  logic [31:0] rsel;

  assign rword = mem[idx];

`ifdef WAIT_MEM_CTRL_SUBWORD_EN
  logic [31:0] rsh_b, rsh_h;
  assign rsh_b = rword >> {lat_addr[1:0], 3'b000};
  assign rsh_h = rword >> {lat_addr[1], 4'b0000};

  always_comb begin
    be   = 4'b1111;
    wd   = lat_wdata;
    rsel = rword;
    case (lat_size)
      2'b00: begin
        be   = 4'b0001 << lat_addr[1:0];
        wd   = {4{lat_wdata[7:0]}};
        rsel = {24'b0, rsh_b[7:0]};
      end
      2'b01: begin
        be   = lat_addr[1] ? 4'b1100 : 4'b0011;
        wd   = {2{lat_wdata[15:0]}};
        rsel = {16'b0, rsh_h[15:0]};
      end
      default: ;
    endcase
  end
`else
  assign be   = 4'b1111;
  assign wd   = lat_wdata;
  assign rsel = rword;
`endif

  // Store commits on the DONE edge unless reset aborts it or it is misaligned.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && lat_we && !lat_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Read is taken from the array during DONE so a preceding store is visible.
  assign resp_rdata   = (resp_valid && !lat_we && !lat_mis) ? rsel : 32'b0;
  assign misalign_err = resp_valid && lat_mis;

endmodule

// File: tb/tb_wait_mem_ctrl.sv
module tb_wait_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       rv, rwe, ready, stall, vld, err;
  logic [1:0][31:0] raddr, rwd, rdata;
  logic [1:0][1:0]  rsz;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  wait_mem_ctrl #(.DEPTH(256), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(raddr[0]),
    .req_wdata(rwd[0]), .req_size(rsz[0]),
    .req_ready(ready[0]), .stall(stall[0]), .resp_valid(vld[0]),
    .resp_rdata(rdata[0]), .misalign_err(err[0])
  );

  wait_mem_ctrl #(.DEPTH(256), .LATENCY(0)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(raddr[1]),
    .req_wdata(rwd[1]), .req_size(rsz[1]),
    .req_ready(ready[1]), .stall(stall[1]), .resp_valid(vld[1]),
    .resp_rdata(rdata[1]), .misalign_err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic access(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input int exp_lat, input logic chk_data,
                        input logic [31:0] exp_data, input logic exp_err,
                        input string tag);
    int  n;
    bit  done;
    rv[d] = 1'b1; rwe[d] = we; raddr[d] = addr; rwd[d] = wdata; rsz[d] = size;
    #1;
    chk({tag, ":ready"}, 32'(ready[d]), 32'd1);
    chk({tag, ":stall_acc"}, 32'(stall[d]), 32'd1);
    @(posedge clk);
    #1 rv[d] = 1'b0;
    n = 0; done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (vld[d]) done = 1;
      else begin
        chk({tag, ":stall_busy"}, 32'(stall[d]), 32'd1);
        chk({tag, ":ready_busy"}, 32'(ready[d]), 32'd0);
        chk({tag, ":rdata_idle"}, rdata[d], 32'd0);
      end
    end
    chk({tag, ":latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ":stall_done"}, 32'(stall[d]), 32'd0);
    chk({tag, ":err"}, 32'(err[d]), 32'(exp_err));
    if (chk_data) chk({tag, ":rdata"}, rdata[d], exp_data);
    @(negedge clk);
    chk({tag, ":vld_drop"}, 32'(vld[d]), 32'd0);
    chk({tag, ":err_drop"}, 32'(err[d]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rv = '0; rwe = '0; raddr = '0; rwd = '0; rsz = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst:ready", 32'(ready[0]), 32'd1);
    chk("rst:vld", 32'(vld[0]), 32'd0);
    chk("rst:stall", 32'(stall[0]), 32'd0);
    chk("rst:rdata", rdata[0], 32'd0);
    chk("rst:err", 32'(err[0]), 32'd0);
    @(negedge clk);

    // LATENCY=2 store/load
    access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 3, 0, 0, 0, "st10");
    access(0, 0, 32'h10, 0, 2'b10, 3, 1, 32'hDEADBEEF, 0, "ld10");
    // misaligned load and store
    access(0, 0, 32'h13, 0, 2'b10, 3, 1, 32'h0, 1, "ld13");
    access(0, 1, 32'h12, 32'h11111111, 2'b10, 3, 0, 0, 1, "st12");
    access(0, 0, 32'h10, 0, 2'b10, 3, 1, 32'hDEADBEEF, 0, "ld10b");
    // wrap-around
    access(0, 1, 32'h400, 32'h55, 2'b10, 3, 0, 0, 0, "st400");
    access(0, 0, 32'h0, 0, 2'b10, 3, 1, 32'h55, 0, "ld000");

    // reset during BUSY aborts the store
    access(0, 1, 32'h20, 32'hCAFE0000, 2'b10, 3, 0, 0, 0, "st20");
    rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 32'h20; rwd[0] = 32'h1234;
    @(posedge clk);
    #1 rv[0] = 1'b0;
    @(negedge clk);
    chk("abort:busy", 32'(stall[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort:vld", 32'(vld[0]), 32'd0);
      chk("abort:ready", 32'(ready[0]), 32'd1);
    end
    access(0, 0, 32'h20, 0, 2'b10, 3, 1, 32'hCAFE0000, 0, "ld20");

    // LATENCY=0
    access(1, 1, 32'h8, 32'hA5A5A5A5, 2'b10, 1, 0, 0, 0, "l0st");
    access(1, 0, 32'h8, 0, 2'b10, 1, 1, 32'hA5A5A5A5, 0, "l0ld");
    access(1, 0, 32'h9, 0, 2'b10, 1, 1, 32'h0, 1, "l0mis");

`ifdef WAIT_MEM_CTRL_SUBWORD_EN
    access(0, 1, 32'h40, 32'h0, 2'b10, 3, 0, 0, 0, "sw_clr");
    access(0, 1, 32'h42, 32'hAB, 2'b00, 3, 0, 0, 0, "sw_stb");
    access(0, 0, 32'h40, 0, 2'b10, 3, 1, 32'h00AB0000, 0, "sw_ldw");
    access(0, 0, 32'h42, 0, 2'b00, 3, 1, 32'h000000AB, 0, "sw_ldb");
    access(0, 1, 32'h41, 32'hFFFF, 2'b01, 3, 0, 0, 1, "sw_sth");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
